// File: rtl/cordic_iter.sv
// cordic_iter: iterative shift/add CORDIC engine (rotation and vectoring) with
// quadrant pre-fold, 1/K gain compensation and saturating sign-magnitude outputs.
module cordic_iter #(
    parameter int               WIDTH = 32,
    parameter int               FRAC  = 30,
    parameter int               AFRAC = 29,
    parameter int               ITER  = 16,
    parameter int               GUARD = 2,
    parameter logic [WIDTH-1:0] KINV  = 32'h26DD3B6B
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             out_sat
);
    localparam int IW = WIDTH + GUARD;
    localparam int PW = IW + WIDTH + 1;
    localparam logic signed [IW-1:0] HALFPI = IW'(32'h3243F6A8);
    localparam logic signed [PW-1:0] KMUL = PW'(KINV);
    localparam logic signed [PW-1:0] SMAX = PW'({(WIDTH-1){1'b1}});
    // atan(2^-i) in Q.29; beyond i=15 the table is exactly 2^(AFRAC-i)
    localparam logic [31:0] ATAN [16] = '{
        32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
        32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
        32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
        32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000
    };

    typedef enum logic [2:0] {IDLE, PREFOLD, ITERATE, SCALE, DONE} stateT;

    stateT                state, nextState;
    logic [1:0]           rstSync;
    logic                 rstN, vect, zeroVec, dir, foldPos, foldNeg, clipX, clipY;
    logic [4:0]           cnt;
    logic signed [IW-1:0] x, y, z, atanI;
    logic signed [PW-1:0] scX, scY, satX, satY;

    function automatic logic signed [IW-1:0] toTc(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -IW'(v[WIDTH-2:0]) : IW'(v[WIDTH-2:0]);
    endfunction

    function automatic logic [WIDTH-1:0] toSm(input logic signed [PW-1:0] v);
        return {v < 0, (WIDTH-1)'(v < 0 ? -v : v)};
    endfunction

    function automatic logic signed [IW-1:0] atanRom(input logic [4:0] i);
        return i < 5'd16 ? IW'(ATAN[i[3:0]]) : IW'(64'd1 << (AFRAC - int'(i)));
    endfunction

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) rstSync <= '0;
        else rstSync <= {rstSync[0], 1'b1};

    assign rstN = rstSync[1];

    always_ff @(posedge clock or negedge rstN)
        if (!rstN) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = in_valid ? PREFOLD : IDLE;
            PREFOLD: nextState = ITERATE;
            ITERATE: nextState = cnt == 5'(ITER - 1) ? SCALE : ITERATE;
            SCALE:   nextState = DONE;
            DONE:    nextState = out_ready ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // foldPos rotates by +pi/2, foldNeg by -pi/2
    assign foldPos = vect ? x < 0 && y < 0 : z > HALFPI;
    assign foldNeg = vect ? x < 0 && y >= 0 : z < -HALFPI;
    assign dir     = vect ? y < 0 : z >= 0;
    assign atanI   = atanRom(cnt);
    assign scX     = (x * KMUL) >>> FRAC;
    assign scY     = (y * KMUL) >>> FRAC;
    assign clipX   = scX > SMAX || scX < -SMAX;
    assign clipY   = scY > SMAX || scY < -SMAX;
    assign satX    = scX > SMAX ? SMAX : scX < -SMAX ? -SMAX : scX;
    assign satY    = scY > SMAX ? SMAX : scY < -SMAX ? -SMAX : scY;

    always_ff @(posedge clock or negedge rstN)
        if (!rstN) begin
            {x, y, z, vect, zeroVec, cnt} <= '0;
            {out_x, out_y, out_z, out_sat} <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x       <= toTc(in_x);
                    y       <= toTc(in_y);
                    z       <= toTc(in_z);
                    vect    <= in_mode;
                    zeroVec <= in_mode && in_x[WIDTH-2:0] == '0 && in_y[WIDTH-2:0] == '0;
                end
                PREFOLD: begin
                    x <= foldPos ? -y : foldNeg ? y : x;
                    y <= foldPos ? x : foldNeg ? -x : y;
                    z <= vect ? (foldPos ? -HALFPI : foldNeg ? HALFPI : '0)
                              : (foldPos ? z - HALFPI : foldNeg ? z + HALFPI : z);
                end
                ITERATE: begin
                    x   <= dir ? x - (y >>> cnt) : x + (y >>> cnt);
                    y   <= dir ? y + (x >>> cnt) : y - (x >>> cnt);
                    // a zero vector has no angle; keep atan2 at 0
                    z   <= zeroVec ? z : dir ? z - atanI : z + atanI;
                    cnt <= cnt + 1'b1;
                end
                SCALE: begin
                    out_x   <= toSm(satX);
                    out_y   <= toSm(satY);
                    out_z   <= toSm(PW'(z));
                    out_sat <= clipX | clipY;
                    cnt     <= '0;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed vectors; the driver queues expected results and an
// independent monitor checks each result (values, saturation, latency) as it appears.
module tb_cordic_iter;
    logic        clock = 0, reset_n = 0, in_valid = 0, in_mode = 0, out_ready = 1;
    logic [31:0] in_x = 0, in_y = 0, in_z = 0;
    logic        in_ready, out_valid, out_sat;
    logic [31:0] out_x, out_y, out_z;
    logic [31:0] sx, sy, sz;
    logic        prevValid = 0;
    int          cyc = 0, tests = 0, fails = 0;

    typedef struct {
        string       name;
        logic [31:0] ex, ey, ez;
        int          tx, ty, tz;
        bit          esat;
        int          acc;
    } expT;

    expT q[$];
    expT mon;

    localparam int TXY = 1 << 16;
    localparam int TZ  = 1 << 15;

    cordic_iter dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_z(out_z), .out_sat(out_sat)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic longint smToInt(input logic [31:0] v);
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint d = act - exp;
        tests++;
        if ((d < 0 ? -d : d) > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", name, act, exp, tol);
        end
    endtask

    // zero tolerance compares the raw word, so a -0 encoding is caught
    task automatic cmpWord(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        if (tol == 0) check(name, longint'(act), longint'(exp), 0);
        else check(name, smToInt(act), smToInt(exp), tol);
    endtask

    function automatic expT mk(input string name, input logic [31:0] ex, ey, ez,
                               input int tx, ty, tz, input bit esat);
        expT e;
        e.name = name; e.ex = ex; e.ey = ey; e.ez = ez;
        e.tx = tx; e.ty = ty; e.tz = tz; e.esat = esat; e.acc = 0;
        return e;
    endfunction

    task automatic send(input bit push, input expT e, input logic m, input logic [31:0] x, y, z);
        expT r = e;
        @(negedge clock);
        in_mode = m; in_x = x; in_y = y; in_z = z; in_valid = 1;
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clock);
        if (!in_ready) begin
            check({e.name, "_accept"}, in_ready, 1, 0);
            in_valid = 0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid = 0;
        r.acc = cyc;
        if (push) q.push_back(r);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (q.size() != 0 || out_valid); k++) @(negedge clock);
        if (q.size() != 0 || out_valid) check("drain", q.size(), 0, 0);
    endtask

    task automatic waitValid();
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clock);
        if (!out_valid) check("wait_valid", out_valid, 1, 0);
    endtask

    always @(negedge clock) begin
        if (out_valid && !prevValid) begin
            if (q.size() == 0) check("spurious_output", out_valid, 0, 0);
            else begin
                mon = q.pop_front();
                cmpWord({mon.name, "_x"}, out_x, mon.ex, mon.tx);
                cmpWord({mon.name, "_y"}, out_y, mon.ey, mon.ty);
                cmpWord({mon.name, "_z"}, out_z, mon.ez, mon.tz);
                check({mon.name, "_sat"}, out_sat, mon.esat, 0);
                // edges counted including the accepting edge
                check({mon.name, "_latency"}, cyc - mon.acc + 1, 19, 0);
            end
        end
        prevValid = out_valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_in_ready", in_ready, 1, 0);
        check("reset_out_valid", out_valid, 0, 0);
        check("reset_out_x", out_x, 0, 0);
        check("reset_out_y", out_y, 0, 0);
        check("reset_out_z", out_z, 0, 0);
        check("reset_out_sat", out_sat, 0, 0);
        reset_n = 1;
        repeat (4) @(negedge clock);

        send(1, mk("rot_pi6", 32'h376CF5D1, 32'h20000000, 0, TXY, TXY, TZ, 0), 0, 32'h40000000, 0, 32'h10C15239);
        drain();
        send(1, mk("rot_m3pi4", 32'hAD413CCD, 32'hAD413CCD, 0, TXY, TXY, TZ, 0), 0, 32'h40000000, 0, 32'hCB65F1FC);
        drain();
        send(1, mk("rot_pi", 32'hC0000000, 0, 0, TXY, TXY, TZ, 0), 0, 32'h40000000, 0, 32'h6487ED51);
        drain();
        send(1, mk("rot_mpi", 32'hC0000000, 0, 0, TXY, TXY, TZ, 0), 0, 32'h40000000, 0, 32'hE487ED51);
        drain();
        send(1, mk("vec_q1", 32'h2D413CCD, 0, 32'h1921FB54, TXY, TXY, TZ, 0), 1, 32'h20000000, 32'h20000000, 0);
        drain();
        send(1, mk("vec_q2", 32'h2D413CCD, 0, 32'h4B65F1FC, TXY, TXY, TZ, 0), 1, 32'hA0000000, 32'h20000000, 0);
        drain();
        send(1, mk("vec_q3", 32'h2D413CCD, 0, 32'hCB65F1FC, TXY, TXY, TZ, 0), 1, 32'hA0000000, 32'hA0000000, 0);
        drain();
        send(1, mk("vec_zero", 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
        drain();

        out_ready = 0;
        send(1, mk("bp", 32'h2D413CCD, 0, 32'h1921FB54, TXY, TXY, TZ, 0), 1, 32'h20000000, 32'h20000000, 0);
        waitValid();
        sx = out_x; sy = out_y; sz = out_z;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; in_mode = 0; in_x = 32'h10000000 + k; in_y = 0; in_z = 0;
            @(negedge clock);
            check("bp_hold", out_x == sx && out_y == sy && out_z == sz && out_valid && !in_ready, 1, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clock);
        #1;
        check("bp_release_valid", out_valid, 0, 0);
        check("bp_release_ready", in_ready, 1, 0);
        check("bp_keep_x", out_x, sx, 0);
        repeat (5) @(negedge clock);
        check("bp_no_second_capture", out_valid, 0, 0);

        send(0, mk("aborted", 0, 0, 0, 0, 0, 0, 0), 0, 32'h40000000, 0, 32'h10C15239);
        repeat (8) @(posedge clock);
        #2 reset_n = 0;
        #1;
        check("rst_mid_out_valid", out_valid, 0, 0);
        check("rst_mid_in_ready", in_ready, 1, 0);
        check("rst_mid_out_x", out_x, 0, 0);
        check("rst_mid_out_y", out_y, 0, 0);
        check("rst_mid_out_z", out_z, 0, 0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        repeat (4) @(negedge clock);
        check("rst_release_ready", in_ready, 1, 0);
        check("rst_release_valid", out_valid, 0, 0);
        send(1, mk("post_reset", 32'h376CF5D1, 32'h20000000, 0, TXY, TXY, TZ, 0), 0, 32'h40000000, 0, 32'h10C15239);
        drain();

        send(1, mk("sat", 0, 32'h7FFFFFFF, 0, 1 << 18, 0, TZ, 1), 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1921FB54);
        drain();
        send(1, mk("neg_zero", 0, 0, 0, 0, 0, TZ, 0), 0, 32'h80000000, 0, 0);
        drain();

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
